// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and load/store.
// Round-robin on ties, one transaction in flight, flush-squashed fetches, read-timeout watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_sel_i,
  output logic              ls_gnt_o,
  output logic              ls_valid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  input  logic              flush_i,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [3:0]        mem_sel_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_valid_i,
  input  logic              mem_ready_i
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

  state_e            r_state, w_state_next;
  logic              r_last_ls;
  logic              r_owner_ls;
  logic              r_we;
  logic              r_drop;
  logic              r_err;
  logic              r_if_valid;
  logic              r_ls_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_ls_data;
  logic [3:0]        r_sel;
  logic [CntW-1:0]   r_cnt;

  logic w_if_cand;
  logic w_arb;
  logic w_pick_ls;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_rd_done;
  logic w_timeout;

  // A flushed fetch must not be started; rst gating keeps grants low while in reset.
  always_comb begin
    w_if_cand = if_req_i & ~flush_i;
    w_arb     = rst & (r_state == StIdle) & mem_ready_i;
    w_pick_ls = ls_req_i & (~w_if_cand | ~r_last_ls);
    w_ls_gnt  = w_arb & w_pick_ls;
    w_if_gnt  = w_arb & w_if_cand & ~w_pick_ls;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_done    = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_if_gnt || w_ls_gnt) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_state_next = r_we ? StIdle : StRdWait;
      end
      StRdWait: begin
        if (mem_valid_i) begin
          w_rd_done    = 1'b1;
          w_state_next = StIdle;
        end else if (r_cnt == CntMax) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_last_ls  <= 1'b0;
      r_owner_ls <= 1'b0;
      r_we       <= 1'b0;
      r_drop     <= 1'b0;
      r_err      <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_data  <= '0;
      r_ls_data  <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_if_valid <= 1'b0;
      r_ls_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_ls_gnt) begin
            r_owner_ls <= 1'b1;
            r_last_ls  <= 1'b1;
            r_we       <= ls_we_i;
            r_addr     <= ls_addr_i;
            r_wdata    <= ls_wdata_i;
            r_sel      <= ls_sel_i;
          end else if (w_if_gnt) begin
            r_owner_ls <= 1'b0;
            r_last_ls  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= if_addr_i;
            r_sel      <= 4'b1111;
          end
        end
        StIssue: begin
          r_cnt <= '0;
          if (!r_owner_ls && flush_i) begin
            r_drop <= 1'b1;
          end
          // Stores are acknowledged as soon as they have been presented.
          if (r_we) begin
            r_ls_valid <= 1'b1;
          end
        end
        StRdWait: begin
          if (w_rd_done) begin
            r_drop <= 1'b0;
            if (r_owner_ls) begin
              r_ls_data  <= mem_data_i;
              r_ls_valid <= 1'b1;
            end else begin
              r_if_data  <= mem_data_i;
              r_if_valid <= ~r_drop;
            end
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_drop <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (!r_owner_ls && flush_i) begin
              r_drop <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign if_gnt_o   = w_if_gnt;
  assign ls_gnt_o   = w_ls_gnt;
  assign if_valid_o = r_if_valid;
  assign ls_valid_o = r_ls_valid;
  assign if_data_o  = r_if_data;
  assign ls_rdata_o = r_ls_data;
  assign err_o      = r_err;
  assign mem_req_o  = (r_state == StIssue);
  assign mem_we_o   = (r_state == StIssue) & r_we;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;
  assign mem_sel_o  = r_sel;

endmodule
